// File: rtl/v_prims_pkg.sv
// Shared encodings for the register primitives: sweep FSM states and the
// read/write strobe polarity.
package v_prims_pkg;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_SWEEP = 1'b1
    } sweep_state_e;

    localparam logic RW_WRITE = 1'b0;
    localparam logic RW_HOLD  = 1'b1;

endpackage

// File: rtl/v_regfile_sweep.sv
// Sweep-clear sequencer: after a clear request, walks clr_idx from 0 to DEPTH-1,
// one word per cycle, with busy high for exactly DEPTH cycles.
module v_regfile_sweep
    import v_prims_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          CLK,
    input  logic          CLR,
    input  logic          zclr,
    output logic          busy,
    output logic          clr_en,
    output logic [AW-1:0] clr_idx
);

    localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

    sweep_state_e  state_reg, state_next;
    logic [AW-1:0] cnt_reg, cnt_next;

    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            state_reg <= S_IDLE;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    // The counter stops at the last index rather than wrapping, so non-power-of-two depths work.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            S_IDLE: begin
                cnt_next = '0;
                if (zclr) state_next = S_SWEEP;
            end
            S_SWEEP: begin
                if (cnt_reg == LAST_IDX) begin
                    state_next = S_IDLE;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_reg + AW'(1);
                end
            end
            default: begin
                state_next = S_IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    always_comb begin
        busy    = (state_reg == S_SWEEP);
        clr_en  = busy;
        clr_idx = cnt_reg;
    end

endmodule

// File: rtl/v_regfile.sv
// Register bank with one write port, two gated combinational read ports,
// write-to-read bypass, written-since-clear bitmap and a sequenced sweep clear.
module v_regfile
    import v_prims_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int DEPTH  = 8,
    parameter int AW     = $clog2(DEPTH),
    parameter bit BYPASS = 1'b1
) (
    input  logic             CLK,
    input  logic             CLR,
    input  logic             R_W,
    input  logic [AW-1:0]    WA,
    input  logic [WIDTH-1:0] D,
    input  logic [AW-1:0]    RA,
    input  logic             Ea,
    output logic [WIDTH-1:0] Qa,
    input  logic [AW-1:0]    RB,
    input  logic             Eb,
    output logic [WIDTH-1:0] Qb,
    input  logic             ZCLR,
    output logic             BUSY,
    output logic [DEPTH-1:0] VLD
);

    localparam logic [AW:0] DEPTH_W = (AW + 1)'(DEPTH);

    logic             busy;
    logic             clr_en;
    logic [AW-1:0]    clr_idx;
    logic             wr_ok;
    logic [WIDTH-1:0] word_q [DEPTH];
    logic [AW-1:0]    rd_addr [2];
    logic             rd_en [2];
    logic [WIDTH-1:0] rd_q [2];

    v_regfile_sweep #(
        .DEPTH(DEPTH),
        .AW   (AW)
    ) u_sweep (
        .CLK    (CLK),
        .CLR    (CLR),
        .zclr   (ZCLR),
        .busy   (busy),
        .clr_en (clr_en),
        .clr_idx(clr_idx)
    );

    assign BUSY  = busy;
    assign wr_ok = (R_W == RW_WRITE) && !busy && ({1'b0, WA} < DEPTH_W);

    genvar gi;

    // Sweep clears and writes never coincide: writes are only accepted while not busy.
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_word
            localparam logic [AW-1:0] IDX = AW'(gi);
            logic [WIDTH-1:0] word_reg;
            logic             vld_reg;

            always_ff @(posedge CLK or negedge CLR) begin
                if (!CLR) begin
                    word_reg <= '0;
                    vld_reg  <= 1'b0;
                end else if (clr_en && (clr_idx == IDX)) begin
                    word_reg <= '0;
                    vld_reg  <= 1'b0;
                end else if (wr_ok && (WA == IDX)) begin
                    word_reg <= D;
                    vld_reg  <= 1'b1;
                end
            end

            assign word_q[gi] = word_reg;
            assign VLD[gi]    = vld_reg;
        end
    endgenerate

    assign rd_addr[0] = RA;
    assign rd_addr[1] = RB;
    assign rd_en[0]   = Ea;
    assign rd_en[1]   = Eb;

    // Disabled or out-of-range ports drive zero so the A/B buses can be OR-merged.
    generate
        for (gi = 0; gi < 2; gi++) begin : g_port
            logic in_range;
            logic hit;

            assign in_range  = ({1'b0, rd_addr[gi]} < DEPTH_W);
            assign hit       = BYPASS && wr_ok && (rd_addr[gi] == WA);
            assign rd_q[gi]  = (rd_en[gi] && in_range) ? (hit ? D : word_q[rd_addr[gi]]) : '0;
        end
    endgenerate

    assign Qa = rd_q[0];
    assign Qb = rd_q[1];

endmodule

// File: tb/tb_v_regfile.sv
// Randomised scoreboard bench: three instances (8/bypass, 8/no-bypass, 6/bypass)
// share one stimulus stream and are checked against a behavioural register-bank model.
module tb_v_regfile;

    logic        CLK = 1'b0;
    logic        CLR = 1'b1;
    logic        R_W = 1'b1;
    logic        Ea = 1'b0, Eb = 1'b0, ZCLR = 1'b0;
    logic [2:0]  WA = '0, RA = '0, RB = '0;
    logic [15:0] D = '0;

    logic [15:0] qa0, qb0, qa1, qb1, qa2, qb2;
    logic [7:0]  vld0, vld1;
    logic [5:0]  vld2;
    logic        busy0, busy1, busy2;

    always #5 CLK = ~CLK;

    v_regfile #(.WIDTH(16), .DEPTH(8), .BYPASS(1'b1)) dut_byp (
        .CLK(CLK), .CLR(CLR), .R_W(R_W), .WA(WA), .D(D),
        .RA(RA), .Ea(Ea), .Qa(qa0), .RB(RB), .Eb(Eb), .Qb(qb0),
        .ZCLR(ZCLR), .BUSY(busy0), .VLD(vld0)
    );

    v_regfile #(.WIDTH(16), .DEPTH(8), .BYPASS(1'b0)) dut_nobyp (
        .CLK(CLK), .CLR(CLR), .R_W(R_W), .WA(WA), .D(D),
        .RA(RA), .Ea(Ea), .Qa(qa1), .RB(RB), .Eb(Eb), .Qb(qb1),
        .ZCLR(ZCLR), .BUSY(busy1), .VLD(vld1)
    );

    v_regfile #(.WIDTH(16), .DEPTH(6), .BYPASS(1'b1)) dut_d6 (
        .CLK(CLK), .CLR(CLR), .R_W(R_W), .WA(WA), .D(D),
        .RA(RA), .Ea(Ea), .Qa(qa2), .RB(RB), .Eb(Eb), .Qb(qb2),
        .ZCLR(ZCLR), .BUSY(busy2), .VLD(vld2)
    );

    typedef struct packed {
        logic [2:0][15:0] qa;
        logic [2:0][15:0] qb;
        logic [2:0][7:0]  vld;
        logic [2:0]       busy;
    } exp_t;

    exp_t exp_q [$];
    int   checks = 0;
    int   errors = 0;
    int   txn    = 0;

    // Behavioural model: per instance a word array, a written bitmap and a sweep position.
    int unsigned m_dep [3] = '{8, 8, 6};
    bit          m_byp [3] = '{1'b1, 1'b0, 1'b1};
    logic [15:0] m_mem [3][8];
    logic [7:0]  m_vld [3];
    bit          m_sweep [3];
    int          m_pos [3];

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            for (int a = 0; a < 8; a++) m_mem[i][a] = '0;
            m_vld[i]   = '0;
            m_sweep[i] = 1'b0;
            m_pos[i]   = 0;
        end
    endtask

    function automatic logic [15:0] model_read(int i, logic [2:0] addr, logic en,
                                               logic rw, logic [2:0] wa, logic [15:0] d);
        if (!en || int'(addr) >= int'(m_dep[i])) return 16'h0000;
        if (m_byp[i] && !rw && !m_sweep[i] && wa == addr) return d;
        return m_mem[i][addr];
    endfunction

    task automatic model_edge(int i, logic rw, logic [2:0] wa, logic [15:0] d, logic zclr);
        if (!m_sweep[i]) begin
            if (!rw && int'(wa) < int'(m_dep[i])) begin
                m_mem[i][wa] = d;
                m_vld[i][wa] = 1'b1;
            end
            if (zclr) begin
                m_sweep[i] = 1'b1;
                m_pos[i]   = 0;
            end
        end else begin
            m_mem[i][m_pos[i]] = '0;
            m_vld[i][m_pos[i]] = 1'b0;
            m_pos[i]++;
            if (m_pos[i] == int'(m_dep[i])) m_sweep[i] = 1'b0;
        end
    endtask

    // One cycle of stimulus: drive just after the edge, predict, then advance the model.
    task automatic step(input logic clr, input logic rw, input logic [2:0] wa,
                        input logic [15:0] d, input logic [2:0] ra, input logic ea,
                        input logic [2:0] rb, input logic eb, input logic zclr);
        exp_t e;
        @(posedge CLK);
        #1;
        CLR = clr; R_W = rw; WA = wa; D = d;
        RA = ra; Ea = ea; RB = rb; Eb = eb; ZCLR = zclr;
        if (!clr) model_reset();
        for (int i = 0; i < 3; i++) begin
            e.qa[i]   = model_read(i, ra, ea, rw, wa, d);
            e.qb[i]   = model_read(i, rb, eb, rw, wa, d);
            e.vld[i]  = m_vld[i];
            e.busy[i] = m_sweep[i];
        end
        exp_q.push_back(e);
        if (clr) for (int i = 0; i < 3; i++) model_edge(i, rw, wa, d, zclr);
    endtask

    task automatic chk(input string name, input int inst, input logic [15:0] act,
                       input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL txn %0d %s inst%0d got %h expected %h", txn, name, inst, act, exp);
        end
    endtask

    logic [2:0][15:0] act_qa, act_qb;
    logic [2:0][7:0]  act_vld;
    logic [2:0]       act_busy;
    assign act_qa   = {qa2, qa1, qa0};
    assign act_qb   = {qb2, qb1, qb0};
    assign act_vld  = {{2'b00, vld2}, vld1, vld0};
    assign act_busy = {busy2, busy1, busy0};

    always @(negedge CLK) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            txn++;
            for (int i = 0; i < 3; i++) begin
                chk("Qa",   i, act_qa[i], e.qa[i]);
                chk("Qb",   i, act_qb[i], e.qb[i]);
                chk("VLD",  i, {8'h00, act_vld[i]}, {8'h00, e.vld[i]});
                chk("BUSY", i, {15'h0, act_busy[i]}, {15'h0, e.busy[i]});
            end
            $display("txn %0d clr=%b rw=%b wa=%0d d=%h ra=%0d/%b rb=%0d/%b z=%b qa=%h busy=%b vld=%h",
                     txn, CLR, R_W, WA, D, RA, Ea, RB, Eb, ZCLR, qa0, busy0, vld0);
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        // Reset state
        step(0, 1, 0, 16'h0, 0, 1, 1, 1, 0);
        step(0, 1, 0, 16'h0, 3, 1, 4, 1, 0);
        // Write/read, enables, both ports on the same word
        step(1, 0, 3, 16'hA5A5, 0, 1, 0, 1, 0);
        step(1, 1, 0, 16'h0, 3, 1, 3, 1, 0);
        step(1, 1, 0, 16'h0, 3, 0, 3, 1, 0);
        // Bypass versus pre-edge value, then post-edge value
        step(1, 0, 5, 16'h1234, 5, 1, 5, 1, 0);
        step(1, 1, 0, 16'h0, 5, 1, 5, 1, 0);
        // Fill everything, sweep with a same-cycle write, writes while busy
        for (int a = 0; a < 8; a++) step(1, 0, 3'(a), 16'($urandom), 3'(a), 1, 3'(7 - a), 1, 0);
        step(1, 0, 2, 16'hBEEF, 2, 1, 7, 1, 1);
        for (int k = 0; k < 10; k++) step(1, 0, 3'(k), 16'hDEAD, 3'(k), 1, 3'(k + 1), 1, 0);
        // Out-of-range write/read for the 6-word instance
        step(1, 0, 7, 16'h7777, 7, 1, 6, 1, 0);
        step(1, 0, 6, 16'h6666, 6, 1, 7, 1, 0);
        step(1, 1, 0, 16'h0, 7, 1, 6, 1, 0);
        // Clear request held high across back-to-back sweeps
        for (int k = 0; k < 20; k++) step(1, 0, 3'($urandom), 16'($urandom), 3'(k), 1, 3'($urandom), 1, 1);
        for (int k = 0; k < 10; k++) step(1, 1, 0, 16'h0, 3'(k), 1, 3'(k + 2), 1, 0);
        // Reset part-way through a sweep
        for (int a = 0; a < 8; a++) step(1, 0, 3'(a), 16'($urandom), 3'(a), 1, 0, 1, 0);
        step(1, 1, 0, 16'h0, 0, 1, 1, 1, 1);
        for (int k = 0; k < 3; k++) step(1, 1, 0, 16'h0, 3'(k), 1, 7, 1, 0);
        step(0, 1, 0, 16'h0, 7, 1, 6, 1, 0);
        step(1, 1, 0, 16'h0, 7, 1, 6, 1, 0);
        step(1, 0, 4, 16'h4444, 4, 1, 4, 1, 0);
        // Randomised traffic
        for (int k = 0; k < 2000; k++) begin
            step(($urandom_range(199) != 0), ($urandom_range(9) < 3), 3'($urandom), 16'($urandom),
                 3'($urandom), ($urandom_range(4) != 0), 3'($urandom), ($urandom_range(4) != 0),
                 ($urandom_range(29) == 0));
        end
        @(negedge CLK);
        @(negedge CLK);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain left %0d expected 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
